arx_conv2d_sram_reader: RTL and testbench



---
 rtl/arx_conv2d_reader_pkg.sv | 34 +++
 rtl/arx_conv2d_stream_fifo.sv | 89 ++++++++
 rtl/arx_conv2d_sram_reader.sv | 219 +++++++++++++++++++++
 tb/tb_arx_conv2d_sram_reader.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/arx_conv2d_reader_pkg.sv
// Shared definitions for the conv2d SRAM reader.
//   rd_state_e     : reader FSM encoding
//   BURST_INCR     : AXI INCR burst type
//   RESP_OKAY      : AXI OKAY response code
//   BOUNDARY_4K    : AXI bursts may not cross this byte boundary
//   bytes_per_beat : data width in bytes
//   axsize         : AXI AxSIZE encoding for a data width
package arx_conv2d_reader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } rd_state_e;

  localparam logic [1:0]  BURST_INCR  = 2'b01;
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam int unsigned BOUNDARY_4K = 4096;

  function automatic int unsigned bytes_per_beat(input int unsigned bw_data);
    return bw_data / 8;
  endfunction

  function automatic logic [2:0] axsize(input int unsigned bw_data);
    logic [2:0] s;
    s = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (bytes_per_beat(bw_data) == (32'd1 << i)) s = 3'(i);
    end
    return s;
  endfunction

endpackage

// File: rtl/arx_conv2d_stream_fifo.sv
// Synchronous FIFO with a registered read port.
// The output register is part of the capacity: count = stored words +
// output-register occupancy, never exceeding DEPTH.
// Ports:
//   clk, rstnn          clock, async active-low reset
//   push, push_data     write side (caller guarantees !full)
//   pop                 consume the word in the output register
//   pop_data            registered head word, valid while !empty
//   full, empty, count  occupancy
module arx_conv2d_stream_fifo #(
  parameter int unsigned DEPTH = 32,
  parameter int unsigned WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       rstnn,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    mem_cnt_q, mem_cnt_d;
  logic             out_vld_q, out_vld_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             mem_we, mem_re, out_free;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    out_vld_d  = out_vld_q;
    out_data_d = out_data_q;
    mem_re     = 1'b0;
    out_free   = !out_vld_q || pop;
    // With storage empty and the output register free, a push bypasses
    // straight into the output register (one cycle push-to-valid).
    mem_we     = push && !(out_free && (mem_cnt_q == '0));
    if (out_free) begin
      if (mem_cnt_q != '0) begin
        out_data_d = mem_q[rd_ptr_q];
        out_vld_d  = 1'b1;
        rd_ptr_d   = rd_ptr_q + AW'(1);
        mem_re     = 1'b1;
      end else if (push) begin
        out_data_d = push_data;
        out_vld_d  = 1'b1;
      end else begin
        out_vld_d  = 1'b0;
      end
    end
    if (mem_we) wr_ptr_d = wr_ptr_q + AW'(1);
    mem_cnt_d = mem_cnt_q + (mem_we ? CW'(1) : CW'(0)) - (mem_re ? CW'(1) : CW'(0));
  end

  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      mem_cnt_q  <= '0;
      out_vld_q  <= 1'b0;
      out_data_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      mem_cnt_q  <= mem_cnt_d;
      out_vld_q  <= out_vld_d;
      out_data_q <= out_data_d;
    end
  end

  // Storage array carries no reset; occupancy is tracked by the counters.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[wr_ptr_q] <= push_data;
  end

  assign pop_data = out_data_q;
  assign empty    = !out_vld_q;
  assign count    = mem_cnt_q + (out_vld_q ? CW'(1) : CW'(0));
  assign full     = (count == CW'(DEPTH));

endmodule

// File: rtl/arx_conv2d_sram_reader.sv
// AXI read master feeding the conv2d datapath from the on-chip SRAM.
// Takes (base address, word count) commands, fetches them as INCR bursts
// that never cross 4 KiB, and streams the words out over valid/ready.
// AR is only issued when the FIFO has room for every beat in flight, so
// rready is tied high.
// Ports:
//   clk, rstnn                      clock, async active-low reset
//   cmd_valid/ready/addr/num_words  command input
//   done, busy                      completion pulse / activity
//   ar*, r*                         AXI read address and data channels
//   st_data/last/valid/ready        output stream
//   err, err_addr                   only with ARX_CONV2D_SRAM_READER_RESP_CHECK_EN:
//                                   sticky non-OKAY flag and first failing address
module arx_conv2d_sram_reader
  import arx_conv2d_reader_pkg::*;
#(
  parameter int unsigned BW_ADDR       = 32,
  parameter int unsigned BW_DATA       = 32,
  parameter int unsigned BW_AXI_TID    = 4,
  parameter int unsigned MAX_BURST_LEN = 16,
  parameter int unsigned FIFO_DEPTH    = 32,
  parameter int unsigned BW_NUM_WORDS  = 16
) (
  input  logic                    clk,
  input  logic                    rstnn,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [BW_ADDR-1:0]      cmd_addr,
  input  logic [BW_NUM_WORDS-1:0] cmd_num_words,
  output logic                    done,
  output logic                    busy,
  output logic [BW_ADDR-1:0]      araddr,
  output logic [7:0]              arlen,
  output logic [2:0]              arsize,
  output logic [1:0]              arburst,
  output logic [BW_AXI_TID-1:0]   arid,
  output logic                    arvalid,
  input  logic                    arready,
  input  logic [BW_AXI_TID-1:0]   rid,
  input  logic [BW_DATA-1:0]      rdata,
  input  logic [1:0]              rresp,
  input  logic                    rlast,
  input  logic                    rvalid,
  output logic                    rready,
  output logic [BW_DATA-1:0]      st_data,
  output logic                    st_last,
  output logic                    st_valid,
  input  logic                    st_ready
`ifdef ARX_CONV2D_SRAM_READER_RESP_CHECK_EN
  ,
  output logic                    err,
  output logic [BW_ADDR-1:0]      err_addr
`endif
);

  localparam logic [2:0]         SIZE       = axsize(BW_DATA);
  localparam int unsigned        CW         = $clog2(FIFO_DEPTH) + 1;
  localparam logic [BW_ADDR-1:0] ALIGN_MASK = ~(BW_ADDR'(bytes_per_beat(BW_DATA) - 1));

  rd_state_e               state_q, state_d;
  logic                    init_q;
  logic [BW_ADDR-1:0]      addr_q, addr_d;
  logic [BW_NUM_WORDS-1:0] remaining_q, remaining_d;
  logic [BW_NUM_WORDS-1:0] num_words_q, num_words_d;
  logic [BW_NUM_WORDS-1:0] stream_cnt_q, stream_cnt_d;
  logic [CW-1:0]           outstanding_q, outstanding_d;

  logic [CW-1:0]           fifo_count;
  logic                    fifo_empty, fifo_full;
  logic [31:0]             wtb_c, len_c, credits_c;
  logic                    cmd_fire, ar_fire, r_acc, st_fire, arvalid_c;

  // Burst sizing and credit gate. Once arvalid rises it cannot fall before
  // the handshake: pushes and beat arrivals cancel in the credit sum and
  // pops only add credit, so araddr/arlen stay put while stalled.
  always_comb begin
    wtb_c = (32'(BOUNDARY_4K) - 32'(addr_q[11:0])) >> SIZE;
    len_c = 32'(MAX_BURST_LEN);
    if (wtb_c < len_c) len_c = wtb_c;
    if (32'(remaining_q) < len_c) len_c = 32'(remaining_q);
    credits_c = 32'(FIFO_DEPTH) - 32'(fifo_count) - 32'(outstanding_q);
    arvalid_c = (state_q == ST_ISSUE) && (credits_c >= len_c);
  end

  assign cmd_ready = (state_q == ST_IDLE) && init_q;
  assign cmd_fire  = cmd_valid && cmd_ready;
  assign ar_fire   = arvalid_c && arready;
  // A beat with nothing outstanding is a protocol violation and is dropped.
  assign r_acc     = rvalid && (outstanding_q != '0);
  assign st_valid  = !fifo_empty;
  assign st_fire   = st_valid && st_ready;
  assign st_last   = st_valid && (stream_cnt_q == num_words_q - BW_NUM_WORDS'(1));

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    remaining_d   = remaining_q;
    num_words_d   = num_words_q;
    stream_cnt_d  = stream_cnt_q;
    if (st_fire) stream_cnt_d = stream_cnt_q + BW_NUM_WORDS'(1);
    outstanding_d = outstanding_q + (ar_fire ? CW'(len_c) : CW'(0))
                                  - (r_acc   ? CW'(1)     : CW'(0));
    case (state_q)
      ST_IDLE: begin
        if (cmd_fire) begin
          addr_d       = cmd_addr & ALIGN_MASK;
          remaining_d  = cmd_num_words;
          num_words_d  = cmd_num_words;
          stream_cnt_d = '0;
          state_d      = (cmd_num_words == '0) ? ST_DONE : ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (ar_fire) begin
          addr_d      = addr_q + BW_ADDR'(len_c << SIZE);
          remaining_d = remaining_q - BW_NUM_WORDS'(len_c);
          if (remaining_d == '0) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if ((outstanding_q == '0) && st_fire && st_last) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      state_q       <= ST_IDLE;
      init_q        <= 1'b0;
      addr_q        <= '0;
      remaining_q   <= '0;
      num_words_q   <= '0;
      stream_cnt_q  <= '0;
      outstanding_q <= '0;
    end else begin
      state_q       <= state_d;
      init_q        <= 1'b1;
      addr_q        <= addr_d;
      remaining_q   <= remaining_d;
      num_words_q   <= num_words_d;
      stream_cnt_q  <= stream_cnt_d;
      outstanding_q <= outstanding_d;
    end
  end

  arx_conv2d_stream_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (BW_DATA)
  ) u_fifo (
    .clk       (clk),
    .rstnn     (rstnn),
    .push      (r_acc),
    .push_data (rdata),
    .pop       (st_fire),
    .pop_data  (st_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign araddr  = addr_q;
  assign arlen   = (state_q == ST_ISSUE) ? 8'(len_c - 32'd1) : 8'd0;
  assign arvalid = arvalid_c;
  assign arsize  = SIZE;
  assign arburst = BURST_INCR;
  assign arid    = '0;
  assign rready  = 1'b1;
  assign done    = (state_q == ST_DONE);
  assign busy    = (state_q != ST_IDLE);

`ifdef ARX_CONV2D_SRAM_READER_RESP_CHECK_EN
  // rx_addr tracks the byte address of the next expected beat; bursts are
  // contiguous, so it simply advances by one word per accepted beat.
  logic               err_q, err_d;
  logic [BW_ADDR-1:0] err_addr_q, err_addr_d;
  logic [BW_ADDR-1:0] rx_addr_q, rx_addr_d;

  always_comb begin
    err_d      = err_q;
    err_addr_d = err_addr_q;
    rx_addr_d  = rx_addr_q;
    if (cmd_fire) begin
      err_d      = 1'b0;
      err_addr_d = '0;
      rx_addr_d  = cmd_addr & ALIGN_MASK;
    end else if (r_acc) begin
      rx_addr_d = rx_addr_q + BW_ADDR'(bytes_per_beat(BW_DATA));
      if ((rresp != RESP_OKAY) && !err_q) begin
        err_d      = 1'b1;
        err_addr_d = rx_addr_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      err_q      <= 1'b0;
      err_addr_q <= '0;
      rx_addr_q  <= '0;
    end else begin
      err_q      <= err_d;
      err_addr_q <= err_addr_d;
      rx_addr_q  <= rx_addr_d;
    end
  end

  assign err      = err_q;
  assign err_addr = err_addr_q;

  logic unused_sink;
  assign unused_sink = ^{rid, rlast, fifo_full};
`else
  logic unused_sink;
  assign unused_sink = ^{rid, rlast, rresp, fifo_full};
`endif

endmodule

// File: tb/tb_arx_conv2d_sram_reader.sv
// Scoreboard bench for arx_conv2d_sram_reader: an AXI slave model serves a
// synthetic memory image, expected AR bursts and stream words are queued by
// the stimulus, and a monitor compares them as the DUT produces them.
module tb_arx_conv2d_sram_reader;

  localparam int FIFO_DEPTH = 32;

  logic        clk = 1'b0;
  logic        rstnn;
  logic        cmd_valid, cmd_ready;
  logic [31:0] cmd_addr;
  logic [15:0] cmd_num_words;
  logic        done, busy;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [3:0]  arid;
  logic        arvalid, arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast, rvalid, rready;
  logic [31:0] st_data;
  logic        st_last, st_valid, st_ready;
`ifdef ARX_CONV2D_SRAM_READER_RESP_CHECK_EN
  logic        err;
  logic [31:0] err_addr;
`endif

  always #5 clk = ~clk;

  arx_conv2d_sram_reader dut (
    .clk(clk), .rstnn(rstnn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_num_words(cmd_num_words), .done(done), .busy(busy),
    .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arid(arid), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
    .rvalid(rvalid), .rready(rready),
    .st_data(st_data), .st_last(st_last), .st_valid(st_valid), .st_ready(st_ready)
`ifdef ARX_CONV2D_SRAM_READER_RESP_CHECK_EN
    , .err(err), .err_addr(err_addr)
`endif
  );

  typedef struct packed { logic [31:0] data; logic last; } st_exp_t;
  typedef struct packed { logic [31:0] addr; logic [7:0] len; } ar_t;

  st_exp_t exp_q[$];
  ar_t     exp_ar[$];
  ar_t     slv_q[$];

  int pass_cnt = 0, chk_cnt = 0;
  int done_cnt = 0, inflight = 0, ar_beats = 0;
  int ar_stall = 0, r_stall = 0, st_mode = 1;   // st_mode: 0 low, 1 high, 2 random
  logic        flush = 1'b0;
  logic [31:0] err_inject = 32'hFFFF_FFFF;
  logic [31:0] cur_addr = 32'd0;
  int          cur_left = 0;

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return {a[15:0] ^ 16'hBEEF, a[17:2]};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic push_words(input logic [31:0] addr, input int n);
    for (int i = 0; i < n; i++)
      exp_q.push_back('{mem_f(addr + 32'(4 * i)), (i == n - 1)});
  endtask

  task automatic push_ar(input logic [31:0] addr, input int len);
    exp_ar.push_back('{addr, 8'(len - 1)});
  endtask

  task automatic issue_cmd(input logic [31:0] addr, input int n);
    int t;
    t = 0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_addr = addr; cmd_num_words = 16'(n);
    #1;
    while (!cmd_ready && t < 50) begin @(negedge clk); #1; t++; end
    if (!cmd_ready) begin
      chk_cnt++;
      $display("FAIL cmd_accept: cmd_ready stayed %0b, required 1", cmd_ready);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int prev, input int budget);
    int t;
    t = 0;
    while (done_cnt == prev && t < budget) begin @(negedge clk); t++; end
    repeat (4) @(negedge clk);
    #3;
    check("done_once", 64'(done_cnt - prev), 64'd1);
    check("stream_drained", 64'(exp_q.size()), 64'd0);
    check("bursts_issued", 64'(exp_ar.size()), 64'd0);
    check("busy_after", 64'(busy), 64'd0);
  endtask

  // AXI slave model + stream sink. Inputs change on the falling edge;
  // handshakes are evaluated #1 later, before the rising edge commits them.
  always @(negedge clk) begin
    if (!rstnn) begin
      arready = 1'b0; rvalid = 1'b0; rlast = 1'b0; rdata = '0; rresp = '0;
      st_ready = 1'b0;
      slv_q.delete(); cur_left = 0;
    end else begin
      arready  = ($urandom_range(99) >= 32'(ar_stall));
      st_ready = (st_mode == 1) ? 1'b1 : (st_mode == 0) ? 1'b0 : 1'($urandom_range(1));
      if (cur_left == 0 && slv_q.size() > 0) begin
        cur_addr = slv_q[0].addr;
        cur_left = int'(slv_q[0].len) + 1;
        void'(slv_q.pop_front());
      end
      if (cur_left > 0 && $urandom_range(99) >= 32'(r_stall)) begin
        rvalid = 1'b1; rdata = mem_f(cur_addr); rlast = (cur_left == 1);
        rresp  = (cur_addr == err_inject) ? 2'b10 : 2'b00;
      end else begin
        rvalid = 1'b0; rdata = '0; rlast = 1'b0; rresp = 2'b00;
      end
      #1;
      if (rstnn) begin
        if (arvalid && arready) slv_q.push_back('{araddr, arlen});
        if (rvalid && rready) begin cur_addr = cur_addr + 32'd4; cur_left--; end
      end
    end
  end

  // Monitor: compares AR bursts and stream words against the queues.
  logic        prev_wait = 1'b0;
  logic [31:0] prev_addr = '0;
  logic [7:0]  prev_len = '0;
  st_exp_t     me;
  ar_t         ma;
  always @(negedge clk) begin
    #2;
    if (rstnn && !flush) begin
      if (prev_wait)
        check("ar_stable", {arvalid, araddr, arlen}, {1'b1, prev_addr, prev_len});
      if (st_valid && st_ready) begin
        inflight--;
        if (exp_q.size() == 0) begin
          chk_cnt++;
          $display("FAIL st_extra: got word %0h, required no word", st_data);
        end else begin
          me = exp_q.pop_front();
          check("st_word", {st_data, st_last}, {me.data, me.last});
        end
      end
      if (arvalid && arready) begin
        ar_beats += int'(arlen) + 1;
        inflight += int'(arlen) + 1;
        if (exp_ar.size() == 0) begin
          chk_cnt++;
          $display("FAIL ar_extra: got addr %0h len %0d, required no burst", araddr, arlen);
        end else begin
          ma = exp_ar.pop_front();
          check("ar_burst", {araddr, arlen}, {ma.addr, ma.len});
        end
        check("credit_bound", 64'(inflight <= FIFO_DEPTH), 64'd1);
      end
      if (done) done_cnt++;
      prev_wait = arvalid && !arready;
      prev_addr = araddr;
      prev_len  = arlen;
    end else begin
      prev_wait = 1'b0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int prev;
  initial begin
    rstnn = 1'b0; cmd_valid = 1'b0; cmd_addr = '0; cmd_num_words = '0;
    rid = '0;
    repeat (3) @(negedge clk);
    #3;
    check("rst_cmd_ready", 64'(cmd_ready), 64'd0);
    check("rst_busy_done", {busy, done, arvalid, st_valid}, 64'd0);
    check("rst_ar", {araddr, arlen}, 64'd0);
    check("const_ar", {arsize, arburst, arid, rready}, {3'd2, 2'b01, 4'd0, 1'b1});
    @(negedge clk); rstnn = 1'b1;
    @(negedge clk); #3;
    check("idle_cmd_ready", 64'(cmd_ready), 64'd1);

    // 40 words from 0: 16,16,8
    push_ar(32'h000, 16); push_ar(32'h040, 16); push_ar(32'h080, 8);
    push_words(32'h0, 40);
    prev = done_cnt; issue_cmd(32'h0, 40); wait_done(prev, 500);
`ifdef ARX_CONV2D_SRAM_READER_RESP_CHECK_EN
    check("err_clear", 64'(err), 64'd0);
`endif

    // 10 words at 0xFF0: split at the 4 KiB boundary
    push_ar(32'h0FF0, 4); push_ar(32'h1000, 6);
    push_words(32'h0FF0, 10);
    prev = done_cnt; issue_cmd(32'h0FF0, 10); wait_done(prev, 500);

    // 100 words with the stream stalled: only FIFO_DEPTH words requested
    st_mode = 0;
    for (int i = 0; i < 6; i++) push_ar(32'h2000 + 32'(64 * i), 16);
    push_ar(32'h2180, 4);
    push_words(32'h2000, 100);
    ar_beats = 0;
    prev = done_cnt; issue_cmd(32'h2000, 100);
    repeat (150) @(negedge clk);
    #3;
    check("stall_beats", 64'(ar_beats), 64'd32);
    check("stall_arvalid", {arvalid, st_valid, busy}, {1'b0, 1'b1, 1'b1});
    st_mode = 1;
    wait_done(prev, 1000);

    // zero-length command
    prev = done_cnt; issue_cmd(32'h500, 0);
    #3;
    check("zero_done_pulse", {done, busy}, {1'b1, 1'b1});
    @(negedge clk); #3;
    check("zero_after", {done, busy, cmd_ready, arvalid}, {1'b0, 1'b0, 1'b1, 1'b0});
    wait_done(prev, 10);

    // 300 words across 0x4000 with random stalls everywhere
    ar_stall = 30; r_stall = 30; st_mode = 2;
    push_ar(32'h3F80, 16); push_ar(32'h3FC0, 16);
    for (int i = 0; i < 16; i++) push_ar(32'h4000 + 32'(64 * i), 16);
    push_ar(32'h4400, 12);
    push_words(32'h3F80, 300);
    prev = done_cnt; issue_cmd(32'h3F80, 300); wait_done(prev, 6000);
    ar_stall = 0; r_stall = 0; st_mode = 1;

    // reset in the middle of a command
    push_ar(32'h100, 16); push_ar(32'h140, 16); push_ar(32'h180, 8);
    push_words(32'h100, 40);
    issue_cmd(32'h100, 40);
    repeat (6) @(negedge clk);
    flush = 1'b1; rstnn = 1'b0;
    #1;
    check("midrst_ar", {arvalid, araddr, arlen}, 64'd0);
    check("midrst_ctl", {st_valid, busy, done, cmd_ready}, 64'd0);
    exp_q.delete(); exp_ar.delete(); inflight = 0;
    repeat (2) @(negedge clk);
    rstnn = 1'b1;
    @(negedge clk);
    flush = 1'b0;

    // recovery command, with an error response on the beat at 0x208
`ifdef ARX_CONV2D_SRAM_READER_RESP_CHECK_EN
    err_inject = 32'h208;
`endif
    push_ar(32'h200, 4);
    push_words(32'h200, 4);
    prev = done_cnt; issue_cmd(32'h200, 4); wait_done(prev, 200);
`ifdef ARX_CONV2D_SRAM_READER_RESP_CHECK_EN
    check("err_flag", {err, err_addr}, {1'b1, 32'h208});
`endif

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
